xbus_arbiter: RTL and testbench

- Round-robin arbiter and multiplexer that shares one xbus slave port between C_NUM_MASTERS xbus master threads.
- Masters use the req/gnt/select/ack protocol: raise ma_req, wait for a one-cycle xbm_gnt, then drive ma_select with address and data until xbm_ack.
- Sits between the producer/consumer memory-traffic threads and the shared memory xbus.

---
 rtl/xbus_pkg.sv | 17 +
 rtl/xbus_arbiter_rr_pick.sv | 36 +++
 rtl/xbus_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_xbus_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbus_pkg.sv
// Shared types and widths for the xbus arbiter slice.
package xbus_pkg;

  // Arbiter FSM states: IDLE (bus free), GRANT (one-cycle grant pulse), BUSY (owner transfers)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } xb_state_t;

  localparam int XB_ADDR_W = 32;
  localparam int XB_DATA_W = 32;
  localparam int XB_BE_W   = 4;
  // Owner index width; covers up to 8 masters
  localparam int XB_IDX_W  = 3;

endpackage

// File: rtl/xbus_arbiter_rr_pick.sv
// Round-robin priority encoder: returns the first set request at or above
// i_ptr, wrapping around. i_ptr must be a valid index (< C_NUM_MASTERS).
module rr_pick
  import xbus_pkg::*;
#(
  parameter int C_NUM_MASTERS = 4
) (
  input  logic [C_NUM_MASTERS-1:0] i_req,
  input  logic [XB_IDX_W-1:0]      i_ptr,
  output logic [XB_IDX_W-1:0]      o_idx,
  output logic                     o_valid
);

  int w_dist;
  int w_best;

  // Choose the requester with the smallest forward distance from the pointer
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_dist  = 0;
    w_best  = 0;
    for (int j = 0; j < C_NUM_MASTERS; j++) begin
      if (i_req[j]) begin
        if (j >= int'(i_ptr)) w_dist = j - int'(i_ptr);
        else                  w_dist = j + C_NUM_MASTERS - int'(i_ptr);
        if (!o_valid || (w_dist < w_best)) begin
          o_valid = 1'b1;
          w_best  = w_dist;
          o_idx   = XB_IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/xbus_arbiter.sv
// Round-robin arbiter/multiplexer sharing one xbus slave among C_NUM_MASTERS
// masters. Optional select watchdog: define XBUS_ARBITER_WDOG_EN to add a
// timeout on the owner's ma_select and the wdog_err pulse output.
//
// Handshake: a master raises ma_req and holds it until it sees its one-cycle
// xbm_gnt pulse (a request dropped earlier is forgotten). After the grant it
// drives ma_select with addr/data/rnw/be; the transfer completes in the cycle
// where xb_select and xb_ack are both high, which is signalled to the owner as
// xbm_ack. The arbiter then returns to IDLE for at least one cycle.
module xbus_arbiter
  import xbus_pkg::*;
#(
  parameter int C_NUM_MASTERS = 4,
  parameter int C_SEL_TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [C_NUM_MASTERS-1:0]       ma_req,
  output logic [C_NUM_MASTERS-1:0]       xbm_gnt,
  input  logic [C_NUM_MASTERS-1:0]       ma_select,
  input  logic [XB_ADDR_W*C_NUM_MASTERS-1:0] ma_addr,
  input  logic [XB_DATA_W*C_NUM_MASTERS-1:0] ma_data,
  input  logic [C_NUM_MASTERS-1:0]       ma_rnw,
  input  logic [XB_BE_W*C_NUM_MASTERS-1:0]   ma_be,
  output logic [C_NUM_MASTERS-1:0]       xbm_ack,
  output logic [XB_DATA_W-1:0]           xbm_data,
  output logic                           xb_select,
  output logic [XB_ADDR_W-1:0]           xb_addr,
  output logic [XB_DATA_W-1:0]           xb_data,
  output logic                           xb_rnw,
  output logic [XB_BE_W-1:0]             xb_be,
  input  logic                           xb_ack,
  input  logic [XB_DATA_W-1:0]           xb_rdata,
  output logic [XB_IDX_W-1:0]            owner,
  output logic                           busy,
`ifdef XBUS_ARBITER_WDOG_EN
  output logic                           wdog_err,
`endif
  output xb_state_t                      dbg_state,
  output logic [XB_IDX_W-1:0]            dbg_rr_ptr
);

  xb_state_t                r_state;
  logic [XB_IDX_W-1:0]      r_rr_ptr;
  logic [XB_IDX_W-1:0]      r_owner;
  logic                     r_busy;
  logic [C_NUM_MASTERS-1:0] r_gnt;

  logic [XB_IDX_W-1:0]      w_pick_idx;
  logic                     w_pick_valid;
  logic [C_NUM_MASTERS-1:0] w_pick_onehot;
  logic [XB_IDX_W-1:0]      w_next_ptr;
  logic                     w_sel;
  logic [XB_ADDR_W-1:0]     w_addr;
  logic [XB_DATA_W-1:0]     w_data;
  logic                     w_rnw;
  logic [XB_BE_W-1:0]       w_be;
  logic                     w_active;
  logic                     w_done;

  rr_pick #(
    .C_NUM_MASTERS (C_NUM_MASTERS)
  ) u_rr_pick (
    .i_req   (ma_req),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // One-hot form of the picked index, loaded into the grant register
  always_comb begin
    w_pick_onehot = '0;
    for (int i = 0; i < C_NUM_MASTERS; i++) begin
      w_pick_onehot[i] = (w_pick_idx == XB_IDX_W'(i));
    end
  end

  // Pointer moves one past the finishing owner, wrapping explicitly so a
  // non-power-of-two master count never yields an out-of-range index
  assign w_next_ptr = (r_owner == XB_IDX_W'(C_NUM_MASTERS - 1)) ? '0 : (r_owner + 3'd1);

  // Select the owner's transfer signals; nobody else can reach the slave
  always_comb begin
    w_sel  = 1'b0;
    w_addr = '0;
    w_data = '0;
    w_rnw  = 1'b0;
    w_be   = '0;
    for (int i = 0; i < C_NUM_MASTERS; i++) begin
      if (r_owner == XB_IDX_W'(i)) begin
        w_sel  = ma_select[i];
        w_addr = ma_addr[i*XB_ADDR_W +: XB_ADDR_W];
        w_data = ma_data[i*XB_DATA_W +: XB_DATA_W];
        w_rnw  = ma_rnw[i];
        w_be   = ma_be[i*XB_BE_W +: XB_BE_W];
      end
    end
  end

  // Slave side is live only in BUSY; reset forces it quiet immediately
  assign w_active  = (r_state == BUSY) && !rst;
  assign xb_select = w_active & w_sel;
  assign xb_addr   = w_active ? w_addr : '0;
  assign xb_data   = w_active ? w_data : '0;
  assign xb_rnw    = w_active & w_rnw;
  assign xb_be     = w_active ? w_be : '0;
  assign w_done    = xb_select & xb_ack;

  // Ack routed only to the owner
  always_comb begin
    xbm_ack = '0;
    for (int i = 0; i < C_NUM_MASTERS; i++) begin
      xbm_ack[i] = w_done && (r_owner == XB_IDX_W'(i));
    end
  end

  assign xbm_data   = xb_rdata;
  assign xbm_gnt    = r_gnt;
  assign owner      = r_owner;
  assign busy       = r_busy;
  assign dbg_state  = r_state;
  assign dbg_rr_ptr = r_rr_ptr;

`ifdef XBUS_ARBITER_WDOG_EN
  localparam int WDOG_W = $clog2(C_SEL_TIMEOUT + 1);

  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_sel_seen;
  logic              r_wdog_err;
  logic              w_timeout;

  // Owner has spent C_SEL_TIMEOUT BUSY cycles without ever raising select
  assign w_timeout = (r_state == BUSY) && !r_sel_seen && !w_sel &&
                     (r_wdog_cnt == WDOG_W'(C_SEL_TIMEOUT - 1));
  assign wdog_err  = r_wdog_err;
`endif

  // Arbiter FSM with registered grant, owner, busy and pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_busy   <= 1'b0;
      r_gnt    <= '0;
`ifdef XBUS_ARBITER_WDOG_EN
      r_wdog_cnt <= '0;
      r_sel_seen <= 1'b0;
      r_wdog_err <= 1'b0;
`endif
    end else begin
      r_gnt <= '0;
`ifdef XBUS_ARBITER_WDOG_EN
      r_wdog_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_owner <= w_pick_idx;
            r_gnt   <= w_pick_onehot;
            r_busy  <= 1'b1;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          r_state <= BUSY;
`ifdef XBUS_ARBITER_WDOG_EN
          r_wdog_cnt <= '0;
          r_sel_seen <= 1'b0;
`endif
        end
        BUSY: begin
          if (w_done) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_rr_ptr <= w_next_ptr;
          end
`ifdef XBUS_ARBITER_WDOG_EN
          else if (w_timeout) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_rr_ptr   <= w_next_ptr;
            r_wdog_err <= 1'b1;
          end else if (w_sel) begin
            r_sel_seen <= 1'b1;
          end else if (!r_sel_seen) begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
          end
`endif
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed bench for xbus_arbiter (4 masters). Watchdog scenario is compiled
// in when XBUS_ARBITER_WDOG_EN is defined.
module tb_xbus_arbiter;
  import xbus_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    ma_req;
  logic [N-1:0]    xbm_gnt;
  logic [N-1:0]    ma_select;
  logic [32*N-1:0] ma_addr;
  logic [32*N-1:0] ma_data;
  logic [N-1:0]    ma_rnw;
  logic [4*N-1:0]  ma_be;
  logic [N-1:0]    xbm_ack;
  logic [31:0]     xbm_data;
  logic            xb_select;
  logic [31:0]     xb_addr;
  logic [31:0]     xb_data;
  logic            xb_rnw;
  logic [3:0]      xb_be;
  logic            xb_ack;
  logic [31:0]     xb_rdata;
  logic [2:0]      owner;
  logic            busy;
  xb_state_t       dbg_state;
  logic [2:0]      dbg_rr_ptr;
`ifdef XBUS_ARBITER_WDOG_EN
  logic            wdog_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

  xbus_arbiter #(.C_NUM_MASTERS(N), .C_SEL_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ma_req(ma_req), .xbm_gnt(xbm_gnt),
    .ma_select(ma_select), .ma_addr(ma_addr), .ma_data(ma_data),
    .ma_rnw(ma_rnw), .ma_be(ma_be), .xbm_ack(xbm_ack), .xbm_data(xbm_data),
    .xb_select(xb_select), .xb_addr(xb_addr), .xb_data(xb_data),
    .xb_rnw(xb_rnw), .xb_be(xb_be), .xb_ack(xb_ack), .xb_rdata(xb_rdata),
    .owner(owner), .busy(busy),
`ifdef XBUS_ARBITER_WDOG_EN
    .wdog_err(wdog_err),
`endif
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    ma_req    = '0;
    ma_select = '0;
    ma_addr   = '0;
    ma_data   = '0;
    ma_rnw    = '0;
    ma_be     = '0;
    xb_ack    = 1'b0;
    xb_rdata  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_master(input int m, input logic [31:0] a, input logic [31:0] d, input logic rnw);
    ma_select[m]       = 1'b1;
    ma_addr[m*32 +: 32] = a;
    ma_data[m*32 +: 32] = d;
    ma_rnw[m]          = rnw;
    ma_be[m*4 +: 4]    = 4'hF;
  endtask

  // Wait (bounded) for any grant pulse; returns zero if none appeared
  task automatic wait_gnt(output logic [N-1:0] g);
    g = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (xbm_gnt != '0) begin
        g = xbm_gnt;
        break;
      end
    end
  endtask

  initial begin
    logic [N-1:0] g;
    int           exp_idx;
    int           wd_cyc;
    clear_inputs();
    rst = 1'b0;

    // Reset state
    do_reset();
    settle();
    check_eq("rst_busy",   32'(busy),       32'd0);
    check_eq("rst_gnt",    32'(xbm_gnt),    32'd0);
    check_eq("rst_state",  32'(dbg_state),  32'(IDLE));
    check_eq("rst_rrptr",  32'(dbg_rr_ptr), 32'd0);
    check_eq("rst_owner",  32'(owner),      32'd0);
    check_eq("rst_xbsel",  32'(xb_select),  32'd0);

    // Single request from master 1, with master 2 selecting illegally
    ma_req = 4'b0010;
    settle();
    check_eq("single_gnt_c0", 32'(xbm_gnt), 32'd0);
    tick();
    check_eq("single_gnt_c1", 32'(xbm_gnt), 32'b0010);
    check_eq("single_busy_g", 32'(busy),    32'd1);
    check_eq("single_owner",  32'(owner),   32'd1);
    ma_req = '0;
    tick();
    check_eq("single_gnt_c2", 32'(xbm_gnt), 32'd0);
    drive_master(1, 32'h0000_0100, 32'h1111_1111, 1'b1);
    drive_master(2, 32'h0000_0200, 32'h2222_2222, 1'b0);
    settle();
    check_eq("iso_addr",   xb_addr,         32'h0000_0100);
    check_eq("iso_data",   xb_data,         32'h1111_1111);
    check_eq("iso_sel",    32'(xb_select),  32'd1);
    check_eq("iso_rnw",    32'(xb_rnw),     32'd1);
    check_eq("iso_be",     32'(xb_be),      32'hF);
    check_eq("ack_before", 32'(xbm_ack),    32'd0);
    xb_ack   = 1'b1;
    xb_rdata = 32'hDEAD_BEEF;
    settle();
    check_eq("single_ack",  32'(xbm_ack), 32'b0010);
    check_eq("single_rdat", xbm_data,     32'hDEAD_BEEF);
    tick();
    clear_inputs();
    settle();
    check_eq("single_busy_done", 32'(busy),       32'd0);
    check_eq("single_rrptr",     32'(dbg_rr_ptr), 32'd2);
    check_eq("idle_xbsel",       32'(xb_select),  32'd0);
    // Slave ack outside BUSY must not reach anyone
    drive_master(2, 32'h0000_0200, 32'h0, 1'b0);
    xb_ack = 1'b1;
    settle();
    check_eq("idle_ack_ignored", 32'(xbm_ack), 32'd0);
    clear_inputs();

    // All four requesting continuously from reset: order 0,1,2,3,0
    do_reset();
    ma_req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_idx = t % N;
      wait_gnt(g);
      check_eq("rr_gnt",   32'(g),     32'(1 << exp_idx));
      check_eq("rr_owner", 32'(owner), 32'(exp_idx));
      tick();
      ma_select[exp_idx] = 1'b1;
      xb_ack = 1'b1;
      settle();
      check_eq("rr_ack", 32'(xbm_ack), 32'(1 << exp_idx));
      tick();
      ma_select = '0;
      xb_ack    = 1'b0;
    end
    clear_inputs();

    // Withdrawn request: master 3 pulses req while master 0 owns the bus
    do_reset();
    ma_req = 4'b0001;
    tick();
    check_eq("wd_gnt0", 32'(xbm_gnt), 32'b0001);
    ma_req = '0;
    tick();
    ma_req = 4'b1000;
    tick();
    ma_req = '0;
    ma_select[0] = 1'b1;
    xb_ack = 1'b1;
    tick();
    clear_inputs();
    for (int c = 0; c < 6; c++) begin
      tick();
      check_eq("withdrawn_no_gnt", 32'(xbm_gnt), 32'd0);
    end
    check_eq("withdrawn_busy", 32'(busy), 32'd0);

    // Reset while BUSY before ack
    ma_req = 4'b0100;
    tick();
    ma_req = '0;
    tick();
    drive_master(2, 32'h0000_0300, 32'h0, 1'b1);
    settle();
    check_eq("rb_sel_pre", 32'(xb_select), 32'd1);
    check_eq("rb_owner",   32'(owner),     32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check_eq("rb_sel_post", 32'(xb_select),  32'd0);
    check_eq("rb_busy",     32'(busy),       32'd0);
    check_eq("rb_rrptr",    32'(dbg_rr_ptr), 32'd0);
    check_eq("rb_state",    32'(dbg_state),  32'(IDLE));
    xb_ack = 1'b1;
    settle();
    check_eq("rb_late_ack", 32'(xbm_ack), 32'd0);
    tick();
    check_eq("rb_late_ack2", 32'(xbm_ack), 32'd0);
    clear_inputs();

`ifdef XBUS_ARBITER_WDOG_EN
    // Watchdog: master 0 granted but never selects, master 1 waiting
    do_reset();
    ma_req = 4'b0001;
    tick();
    ma_req = 4'b0010;
    tick();
    wd_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (wdog_err) begin
        wd_cyc = c;
        break;
      end
    end
    check_eq("wdog_cycle", 32'(wd_cyc),     32'(TMO));
    check_eq("wdog_state", 32'(dbg_state),  32'(IDLE));
    check_eq("wdog_rrptr", 32'(dbg_rr_ptr), 32'd1);
    tick();
    check_eq("wdog_pulse_end", 32'(wdog_err), 32'd0);
    check_eq("wdog_next_gnt",  32'(xbm_gnt),  32'b0010);
    clear_inputs();
    do_reset();
`else
    wd_cyc = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
